// File: rtl/motor_mixer_pkg.sv
// Shared constants and state encoding for the quad-X motor mixer and its channel scaler.
package motor_mixer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StScale,
    StMix0,
    StMix1,
    StMix2,
    StMix3,
    StDone
  } mix_state_e;

  // Nominal SBUS/FPort channel range.
  localparam int unsigned SBUS_INPUT_MIN = 192;
  localparam int unsigned SBUS_INPUT_MID = 992;
  localparam int unsigned SBUS_INPUT_MAX = 1792;

  // Raw channel to microseconds: us = 5*raw/8 + 880, centred on 1500.
  localparam logic signed [15:0] SCALE_OFFSET = 16'sd880;
  localparam logic signed [15:0] SCALE_CENTER = 16'sd1500;
  localparam logic signed [15:0] SCALE_SPAN   = 16'sd2000;

  localparam int unsigned        DSHOT_MIN_DEFAULT = 48;
  localparam logic signed [15:0] DSHOT_MAX         = 16'sd2047;

  localparam int unsigned MOTOR_COUNT = 4;

  // Per-motor {roll,pitch,yaw} subtract bits for the 3^1 / X / 2 0 layout.
  localparam logic [11:0] MIX_NEG_DEFAULT = 12'hB83;

endpackage

// File: rtl/motor_mixer_scale.sv
// Combinational raw-channel scaler: maps 192..1792 onto a signed -2000..+2000 range.
module rc_scale
  import motor_mixer_pkg::*;
(
  input  logic [10:0]        raw,
  output logic signed [15:0] scaled
);

  logic [13:0]        prod;
  logic [10:0]        div;
  logic signed [15:0] centred;

  always_comb begin
    prod    = {3'b000, raw} * 14'd5;
    div     = prod[13:3];
    centred = $signed({5'b00000, div}) + SCALE_OFFSET - SCALE_CENTER;
    scaled  = centred <<< 2;
  end

endmodule

// File: rtl/motor_mixer.sv
// Sequential quad-X mixer: latches stick channels on start, mixes one motor per cycle
// through a shared adder/clamp, and publishes all four DShot commands with a valid pulse.
module motor_mixer
  import motor_mixer_pkg::*;
#(
  parameter logic [11:0] MIX_NEG    = MIX_NEG_DEFAULT,
  parameter int unsigned AXIS_SHIFT = 2,
  parameter int unsigned THR_MAX    = 1000,
  parameter int unsigned DSHOT_MIN  = DSHOT_MIN_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        armed,
  input  logic [10:0] rc_throttle,
  input  logic [10:0] rc_roll,
  input  logic [10:0] rc_pitch,
  input  logic [10:0] rc_yaw,
  output logic        busy,
  output logic        valid,
  output logic [10:0] motor_cmd0,
  output logic [10:0] motor_cmd1,
  output logic [10:0] motor_cmd2,
  output logic [10:0] motor_cmd3
);

  localparam logic signed [15:0] ThrMaxS   = 16'(THR_MAX);
  localparam logic signed [15:0] DshotMinS = 16'(DSHOT_MIN);

  mix_state_e state_q, state_d;

  logic [10:0] raw_thr_q, raw_roll_q, raw_pitch_q, raw_yaw_q;
  logic        armed_q;

  logic signed [15:0] s_thr, s_roll, s_pitch, s_yaw;
  logic signed [15:0] thr_sum, thr_term_d;
  logic signed [15:0] thr_term_q, a_roll_q, a_pitch_q, a_yaw_q;

  logic [2:0]         neg;
  logic signed [15:0] v, vc, dsh;
  logic [10:0]        mix_cmd;

  logic [MOTOR_COUNT-1:0][10:0] shadow_q;
  logic [MOTOR_COUNT-1:0][10:0] cmd_q;

  rc_scale u_scale_thr   (.raw(raw_thr_q),   .scaled(s_thr));
  rc_scale u_scale_roll  (.raw(raw_roll_q),  .scaled(s_roll));
  rc_scale u_scale_pitch (.raw(raw_pitch_q), .scaled(s_pitch));
  rc_scale u_scale_yaw   (.raw(raw_yaw_q),   .scaled(s_yaw));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StScale;
      StScale: state_d = StMix0;
      StMix0:  state_d = StMix1;
      StMix1:  state_d = StMix2;
      StMix2:  state_d = StMix3;
      StMix3:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    thr_sum    = s_thr + SCALE_SPAN;
    thr_term_d = thr_sum[15] ? 16'sd0 : (thr_sum >>> 2);
  end

  // Shared mixing datapath; the active motor is implied by the MIXm state.
  always_comb begin
    case (state_q)
      StMix1:  neg = MIX_NEG[5:3];
      StMix2:  neg = MIX_NEG[8:6];
      StMix3:  neg = MIX_NEG[11:9];
      default: neg = MIX_NEG[2:0];
    endcase

    v = thr_term_q
      + (neg[2] ? -a_roll_q  : a_roll_q)
      + (neg[1] ? -a_pitch_q : a_pitch_q)
      + (neg[0] ? -a_yaw_q   : a_yaw_q);

    if (v < 16'sd0)        vc = 16'sd0;
    else if (v > ThrMaxS)  vc = ThrMaxS;
    else                   vc = v;

    dsh = DshotMinS + (vc <<< 1);

    if (!armed_q)              mix_cmd = 11'd0;
    else if (dsh > DSHOT_MAX)  mix_cmd = 11'h7ff;
    else                       mix_cmd = dsh[10:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      raw_thr_q   <= '0;
      raw_roll_q  <= '0;
      raw_pitch_q <= '0;
      raw_yaw_q   <= '0;
      armed_q     <= 1'b0;
      thr_term_q  <= '0;
      a_roll_q    <= '0;
      a_pitch_q   <= '0;
      a_yaw_q     <= '0;
      shadow_q    <= '0;
      cmd_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        raw_thr_q   <= rc_throttle;
        raw_roll_q  <= rc_roll;
        raw_pitch_q <= rc_pitch;
        raw_yaw_q   <= rc_yaw;
        armed_q     <= armed;
      end
      if (state_q == StScale) begin
        thr_term_q <= thr_term_d;
        a_roll_q   <= s_roll >>> AXIS_SHIFT;
        a_pitch_q  <= s_pitch >>> AXIS_SHIFT;
        a_yaw_q    <= s_yaw >>> AXIS_SHIFT;
      end
      case (state_q)
        StMix0: shadow_q[0] <= mix_cmd;
        StMix1: shadow_q[1] <= mix_cmd;
        StMix2: shadow_q[2] <= mix_cmd;
        StMix3: begin
          // Commands land on the edge into DONE so they are visible with valid.
          shadow_q[3] <= mix_cmd;
          cmd_q[0]    <= shadow_q[0];
          cmd_q[1]    <= shadow_q[1];
          cmd_q[2]    <= shadow_q[2];
          cmd_q[3]    <= mix_cmd;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q == StScale) || (state_q == StMix0) || (state_q == StMix1) ||
                      (state_q == StMix2)  || (state_q == StMix3);
  assign valid      = (state_q == StDone);
  assign motor_cmd0 = cmd_q[0];
  assign motor_cmd1 = cmd_q[1];
  assign motor_cmd2 = cmd_q[2];
  assign motor_cmd3 = cmd_q[3];

endmodule

// File: tb/tb_motor_mixer.sv
// Directed bench for motor_mixer: hand-computed mixes, latency, busy window and reset abort.
module tb_motor_mixer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        armed;
  logic [10:0] rc_throttle, rc_roll, rc_pitch, rc_yaw;
  logic        busy, valid;
  logic [10:0] motor_cmd0, motor_cmd1, motor_cmd2, motor_cmd3;

  int total;
  int bad;

  motor_mixer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .armed      (armed),
    .rc_throttle(rc_throttle),
    .rc_roll    (rc_roll),
    .rc_pitch   (rc_pitch),
    .rc_yaw     (rc_yaw),
    .busy       (busy),
    .valid      (valid),
    .motor_cmd0 (motor_cmd0),
    .motor_cmd1 (motor_cmd1),
    .motor_cmd2 (motor_cmd2),
    .motor_cmd3 (motor_cmd3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one start and watches a bounded window; dup_k > 0 re-pulses start k cycles later.
  task automatic run_mix(input string tag, input logic arm, input logic [10:0] thr,
                         input logic [10:0] roll, input logic [10:0] pitch,
                         input logic [10:0] yaw, input int dup_k,
                         input logic [10:0] e0, input logic [10:0] e1,
                         input logic [10:0] e2, input logic [10:0] e3);
    int busy_cnt;
    int valid_cnt;
    int valid_k;
    busy_cnt  = 0;
    valid_cnt = 0;
    valid_k   = 0;
    @(negedge clock);
    armed       = arm;
    rc_throttle = thr;
    rc_roll     = roll;
    rc_pitch    = pitch;
    rc_yaw      = yaw;
    start       = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clock);
      start = (k == dup_k);
      if (busy) busy_cnt++;
      if (valid) begin
        valid_cnt++;
        if (valid_k == 0) begin
          valid_k = k;
          check({tag, "_cmd0"}, 32'(motor_cmd0), 32'(e0));
          check({tag, "_cmd1"}, 32'(motor_cmd1), 32'(e1));
          check({tag, "_cmd2"}, 32'(motor_cmd2), 32'(e2));
          check({tag, "_cmd3"}, 32'(motor_cmd3), 32'(e3));
        end
      end
    end
    check({tag, "_valid_at"}, 32'(valid_k), 32'd6);
    check({tag, "_valid_cnt"}, 32'(valid_cnt), 32'd1);
    check({tag, "_busy_len"}, 32'(busy_cnt), 32'd5);
    check({tag, "_hold0"}, 32'(motor_cmd0), 32'(e0));
  endtask

  initial begin
    int stray;
    total       = 0;
    bad         = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    armed       = 1'b0;
    rc_throttle = 11'd0;
    rc_roll     = 11'd0;
    rc_pitch    = 11'd0;
    rc_yaw      = 11'd0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_cmd0", 32'(motor_cmd0), 32'd0);
    check("rst_cmd3", 32'(motor_cmd3), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_busy", 32'(busy), 32'd0);

    run_mix("centre", 1'b1, 11'd992, 11'd992, 11'd992, 11'd992, 0,
            11'd1048, 11'd1048, 11'd1048, 11'd1048);
    run_mix("thr_low", 1'b1, 11'd192, 11'd992, 11'd992, 11'd992, 0,
            11'd48, 11'd48, 11'd48, 11'd48);
    run_mix("disarmed", 1'b0, 11'd192, 11'd992, 11'd992, 11'd992, 0,
            11'd0, 11'd0, 11'd0, 11'd0);
    run_mix("roll_full", 1'b1, 11'd992, 11'd1792, 11'd992, 11'd992, 0,
            11'd2047, 11'd2047, 11'd48, 11'd48);
    run_mix("pitch_low", 1'b1, 11'd1792, 11'd992, 11'd192, 11'd992, 0,
            11'd2047, 11'd1048, 11'd2047, 11'd1048);
    // Raw 2047 on throttle, yaw 192: thr_term 1159, a_yaw -500.
    run_mix("over_range", 1'b1, 11'd2047, 11'd992, 11'd992, 11'd192, 0,
            11'd2047, 11'd1366, 11'd1366, 11'd2047);
    run_mix("dup_start", 1'b1, 11'd992, 11'd992, 11'd992, 11'd992, 2,
            11'd1048, 11'd1048, 11'd1048, 11'd1048);

    // Abort mid-computation with reset.
    @(negedge clock);
    armed       = 1'b1;
    rc_throttle = 11'd1792;
    rc_roll     = 11'd992;
    rc_pitch    = 11'd992;
    rc_yaw      = 11'd992;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_cmd0", 32'(motor_cmd0), 32'd0);
    check("abort_cmd2", 32'(motor_cmd2), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    stray = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (valid) stray++;
    end
    check("abort_no_valid", 32'(stray), 32'd0);
    check("abort_cmd1_held", 32'(motor_cmd1), 32'd0);

    run_mix("post_reset", 1'b1, 11'd992, 11'd992, 11'd992, 11'd992, 0,
            11'd1048, 11'd1048, 11'd1048, 11'd1048);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_mixer.md
Name: motor_mixer

Overview:
Sequential quad-X motor mixer between fport_rx_decoder and the four motor_control instances.
- On a start strobe it latches the raw 11-bit SBUS/FPort stick channels and the arm flag.
- It rescales the channels and applies per-motor roll/pitch/yaw signs, time-sharing one adder/clamp datapath across the four motors.
- It presents four registered 11-bit DShot commands with a one-cycle valid strobe.
- It replaces the combinational mixing in the top level, which then drives the motor send strobe from valid.

Parameters:
- MIX_NEG, 12'hB83: per-motor axis sign bits, motor m at [3m+2:3m] = {roll,pitch,yaw}; 1 = subtract. The default gives the layout 3^1 / X / 2 0.
- AXIS_SHIFT, 2: arithmetic right shift applied to scaled roll/pitch/yaw.
- THR_MAX, 1000: upper clamp of the mixed motor value.
- DSHOT_MIN, 48: lowest armed DShot throttle command.

Ports:
- clock, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- start, in, 1: one-cycle request to compute a new mix.
- armed, in, 1: arm state, sampled with start.
- rc_throttle, in, 11: raw channel value (192..1792 nominal).
- rc_roll, in, 11: raw channel value.
- rc_pitch, in, 11: raw channel value.
- rc_yaw, in, 11: raw channel value.
- busy, out, 1: high from the cycle after start is accepted until valid.
- valid, out, 1: one-cycle pulse; all commands updated that cycle.
- motor_cmd0, out, 11: DShot command for motor 0.
- motor_cmd1, out, 11: DShot command for motor 1.
- motor_cmd2, out, 11: DShot command for motor 2.
- motor_cmd3, out, 11: DShot command for motor 3.

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0, valid=0, motor_cmd0..3=0, shadow registers=0.
- Reset asserted mid-computation aborts it. No valid pulse is produced and outputs return to 0.
- States: IDLE -> SCALE -> MIX0 -> MIX1 -> MIX2 -> MIX3 -> DONE -> IDLE.
- IDLE:
  - start=1 latches the four rc_* inputs and armed, then goes to SCALE.
  - start while not IDLE is ignored (no queueing).
- SCALE: for each channel, s = ((5*raw)/8 + 880 - 1500) * 4.
  - Unsigned multiply, truncating divide; result signed 16-bit.
  - 192 gives -2000, 992 gives 0, 1792 gives +2000.
  - thr_term = (s_thr + 2000) >>> 2, clamped below at 0.
  - axis terms a = s >>> AXIS_SHIFT (arithmetic, floor).
- MIXm (one cycle per motor):
  - v = thr_term ± a_roll ± a_pitch ± a_yaw, signs from MIX_NEG; signed 16-bit, no overflow possible.
  - vc = clamp(v, 0, THR_MAX).
  - shadow_m = armed_latched ? min(DSHOT_MIN + 2*vc, 2047) : 0.
  - Command 0 means disarmed; DShot values 1..47 are never emitted.
- DONE:
  - motor_cmd0..3 <= shadow0..3 simultaneously; valid=1 for exactly this cycle; busy=0 from this cycle.
  - Returns to IDLE; start is accepted again on the next cycle.
- Latency: start sampled on edge N, valid high in cycle N+6. The maximum start rate is one per 7 cycles.
- busy is high in SCALE through MIX3.
- Outputs hold their last values between valid pulses.
- Raw inputs above 1792 (up to 2047) are legal; the clamps absorb them.

Decomposition:
- Shared include (rc_defs.vh):
  - SBUS_INPUT_MIN/MID/MAX and the scaling constants 880/1500.
  - DSHOT_MIN and DSHOT_MAX (2047).
  - The motor index defines and MIX_NEG default.
- Natural sub-module: rc_scale, the combinational raw-to-signed ±2000 scaler, instanced four times in SCALE.
- The state machine, adder and clamp stay in motor_mixer.

Test Plan:
1. armed=1, all channels 992, start -> valid at N+6; all four cmds = 1048; busy high for cycles N+1..N+5.
2. armed=1, throttle 192, others 992 -> all cmds = 48. Same stimulus with armed=0 -> all cmds = 0.
3. armed=1, throttle 992, roll 1792, pitch/yaw 992 -> cmd0=cmd1=2047 (v=1000 clamps via min), cmd2=cmd3=1048-1000 clamp → v=0 → 48.
4. armed=1, throttle 1792, pitch 192, others 992 -> motors with pitch sign negative (0,2): v=1500 clamped → 2047; motors 1,3: v=500 → 1048.
5. A start pulse at N+2 during busy is ignored: exactly one valid at N+6 and no second pulse within 20 cycles.
6. reset_n low at N+3 -> cmds 0 immediately, no valid. After release, a new start produces the correct result of scenario 1.
